// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with sticky overrun/frame error flags.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 234,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          uart_rx,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [7:0]                    rd_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          frame_err
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

   state_t          state, state_next;
   logic            rx_m, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            cnt_clr, shift_en, push, frame_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, do_pop, do_push, drop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= uart_rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      push       = 1'b0;
      frame_set  = 1'b0;
      case (state)
         IDLE: if (!rx_s) begin
            cnt_clr    = 1'b1;
            state_next = START;
         end
         START: if (cnt == CNT_HALF) begin
            cnt_clr    = 1'b1;
            state_next = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt == CNT_LAST) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
            if (bit_idx == 3'd7) state_next = STOP;
         end
         STOP: if (cnt == CNT_LAST) begin
            cnt_clr = 1'b1;
            if (rx_s) begin
               push       = 1'b1;
               state_next = IDLE;
            end else begin
               frame_set  = 1'b1;
               state_next = RECOVER;
            end
         end
         RECOVER: if (rx_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // cnt free-runs outside the timed states; every timed state is entered with a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 1'b1;
         if (state != DATA)  bit_idx <= '0;
         else if (shift_en)  bit_idx <= bit_idx + 1'b1;
         if (shift_en) shreg <= {rx_s, shreg[7:1]};
      end
   end

   assign fifo_count = wr_ptr - rd_ptr;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign do_pop     = rd_en && !empty;
   assign do_push    = push && (!full || do_pop);
   assign drop       = push && full && !do_pop;
   assign rx_valid   = !empty;
   assign rd_data    = mem[rd_ptr[AW-1:0]];

   // When full, a simultaneous pop frees the very slot the push lands in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (drop)         overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
         if (frame_set)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Bench for uart_receiver: directed frame scenarios plus random traffic,
// scored against a byte-queue model of the receive FIFO and its flags.
module tb_uart_receiver;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic [3:0] fifo_count;
   logic       overrun;
   logic       frame_err;

   uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .uart_rx    (uart_rx),
      .rd_en      (rd_en),
      .err_clr    (err_clr),
      .rd_data    (rd_data),
      .rx_valid   (rx_valid),
      .fifo_count (fifo_count),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   logic       ovr_m  = 1'b0;
   logic       ferr_m = 1'b0;
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at a negedge; optional rd_en pulse lands on the stop-sample edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len,
                             input bit pop_at_stop);
      uart_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(CPB);
      end
      uart_rx = stop_val;
      for (int i = 0; i < stop_len; i++) begin
         if (pop_at_stop) rd_en = (i == 10);
         @(negedge clk);
      end
      rd_en   = 1'b0;
      uart_rx = 1'b1;
   endtask

   function automatic void model_frame(input logic [7:0] b, input bit good);
      if (!good)                    ferr_m = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                          ovr_m = 1'b1;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1, CPB, 1'b0);
      idle(4);
      model_frame(b, 1'b1);
   endtask

   task automatic check_state(input string tag);
      check({tag, "/count"}, 32'(fifo_count), 32'(exp_q.size()));
      check({tag, "/valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
      check({tag, "/overrun"}, 32'(overrun), 32'(ovr_m));
      check({tag, "/frame_err"}, 32'(frame_err), 32'(ferr_m));
      if (exp_q.size() != 0) check({tag, "/head"}, 32'(rd_data), 32'(exp_q[0]));
   endtask

   task automatic pop_one(input string tag);
      check({tag, "/pop_valid"}, 32'(rx_valid), 32'd1);
      if (exp_q.size() != 0) begin
         check({tag, "/pop_data"}, 32'(rd_data), 32'(exp_q[0]));
         void'(exp_q.pop_front());
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic clear_flags();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      ovr_m   = 1'b0;
      ferr_m  = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/rd_data"}, 32'(rd_data), 32'h0);
      check({tag, "/valid"}, 32'(rx_valid), 32'h0);
      check({tag, "/count"}, 32'(fifo_count), 32'h0);
      check({tag, "/overrun"}, 32'(overrun), 32'h0);
      check({tag, "/frame_err"}, 32'(frame_err), 32'h0);
   endtask

   initial begin
      logic [7:0] b;
      bit         good;

      idle(3);
      check_reset_values("reset");
      reset = 1'b0;
      idle(5);

      // Two back-to-back bytes, read out in order.
      send_byte(8'h55);
      send_byte(8'hA3);
      check_state("t1");
      pop_one("t1a");
      check_state("t1_after_pop");
      pop_one("t1b");
      check_state("t1_empty");

      // Pop while empty is ignored.
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check_state("empty_pop");

      // Short low glitch must not start a frame.
      uart_rx = 1'b0;
      idle(5);
      uart_rx = 1'b1;
      idle(30);
      check_state("t2_glitch");
      send_byte(8'h5A);
      check_state("t2_after");
      pop_one("t2");

      // Stop bit held low: byte dropped, frame_err until cleared.
      send_frame(8'h3C, 1'b0, 40, 1'b0);
      model_frame(8'h3C, 1'b0);
      idle(20);
      check_state("t3_ferr");
      send_byte(8'h81);
      check_state("t3_next");
      clear_flags();
      check_state("t3_clr");
      pop_one("t3");

      // Overfill: ninth byte lost, overrun set.
      for (int i = 0; i < 9; i++) send_byte(8'(i));
      check_state("t4_full");
      for (int i = 0; i < 8; i++) pop_one("t4_drain");
      check_state("t4_empty");
      clear_flags();
      check_state("t4_clr");

      // Full FIFO, pop coinciding with the push of 0x77.
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)));
      check_state("t5_full");
      send_frame(8'h77, 1'b1, CPB, 1'b1);
      idle(4);
      void'(exp_q.pop_front());
      exp_q.push_back(8'h77);
      check_state("t5_pushpop");
      for (int i = 0; i < DEPTH; i++) pop_one("t5_drain");
      check_state("t5_empty");

      // Reset in the middle of data bit 4 discards everything.
      send_byte(8'h11);
      b = 8'($urandom_range(0, 255));
      uart_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         uart_rx = b[i];
         idle(CPB);
      end
      uart_rx = b[4];
      idle(CPB / 2);
      reset = 1'b1;
      idle(2);
      check_reset_values("t6_reset");
      uart_rx = 1'b1;
      reset   = 1'b0;
      exp_q.delete();
      ovr_m  = 1'b0;
      ferr_m = 1'b0;
      idle(5);
      send_byte(8'hC9);
      check_state("t6_after");
      pop_one("t6");
      check_state("t6_empty");

      // Random traffic with occasional bad stop bits, pops and flag clears.
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 7) != 0);
         send_frame(b, good, CPB, 1'b0);
         idle($urandom_range(4, 12));
         model_frame(b, good);
         check_state("rand");
         if ($urandom_range(0, 3) == 0) begin
            clear_flags();
            check_state("rand_clr");
         end
         for (int k = $urandom_range(0, 2); k > 0 && exp_q.size() != 0; k--) pop_one("rand_pop");
      end
      while (exp_q.size() != 0) pop_one("final_drain");
      check_state("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
